// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction width, canonical NOP,
// default reset vector and the fetch buffer entry layout.
package cpu_pkg;

    localparam int              ILEN             = 32;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [ILEN-1:0] align_word(input logic [ILEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO of {pc, instr} entries between the
// memory response port and the decode-facing output register.
// Flush has priority over push and pop.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_entry,
    output fetch_entry_t     head_entry,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && !flush;
    assign do_pop     = pop && !flush && !empty;
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head_entry = mem[rd_ptr];

    // Entry storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// fetch: owns the program counter, keeps at most one instruction-memory
// request in flight, discards responses made stale by a redirect, and
// drives the decode-facing output register from the fetch buffer.
module fetch
    import cpu_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [ILEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [ILEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [ILEN-1:0] next_instruction,
    output logic [ILEN-1:0] pc_out,
    output logic            valid_out
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ILEN-1:0]  fetch_pc;
    logic [ILEN-1:0]  req_pc;
    logic             outstanding;
    logic             drop;

    logic             accept;
    logic             resp;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_empty;
    logic             buf_full;
    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    logic [ILEN-1:0]  instr_p1;
    logic [ILEN-1:0]  pc_p1;
    logic             vld_p1;

    // Only one request in flight and only with a free slot, so every
    // response is guaranteed room in the buffer.
    assign imem_req  = !rst && !outstanding && (buf_count < CNT_W'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    // A response with nothing outstanding (e.g. one that straddled a reset) is ignored.
    assign resp      = imem_rvalid && outstanding;
    assign buf_push  = resp && !drop && !redirect;
    assign buf_pop   = !redirect && !stall && !buf_empty;

    assign push_entry.pc    = req_pc;
    assign push_entry.instr = imem_rdata;

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .pop        (buf_pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (buf_count),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    // PC, in-flight flag and stale-response drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= align_word(redirect_pc);
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (accept) begin
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end

            // A response returning in the redirect cycle is flushed directly,
            // so only a request still pending afterwards needs dropping.
            if (redirect) begin
                drop <= (outstanding && !imem_rvalid) || accept;
            end else if (resp) begin
                drop <= 1'b0;
            end
        end
    end

    // Address of the request in flight, paired with its response on push.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc <= fetch_pc;
        end
    end

    // Output register: buffer head -> decode; NOP bubble when empty or redirected.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= NOP_INSTR;
            pc_p1    <= RESET_PC;
            vld_p1   <= 1'b0;
        end else if (redirect) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else if (!stall) begin
            if (buf_empty) begin
                instr_p1 <= NOP_INSTR;
                vld_p1   <= 1'b0;
            end else begin
                instr_p1 <= head_entry.instr;
                pc_p1    <= head_entry.pc;
                vld_p1   <= 1'b1;
            end
        end
    end

    assign next_instruction = instr_p1;
    assign pc_out           = pc_p1;
    assign valid_out        = vld_p1;

    // The issue rule must make a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (rst) !(buf_push && buf_full));

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: randomized memory/stall/redirect stimulus checked every
// cycle against a queue-based behavioural model, plus directed scenarios
// with hand-computed expectations.
`timescale 1ns/1ps
module tb_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] next_instruction;
    logic [31:0] pc_out;
    logic        valid_out;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .stall            (stall),
        .next_instruction (next_instruction),
        .pc_out           (pc_out),
        .valid_out        (valid_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: addi x1,x1,<word index> at every address.
    function automatic logic [31:0] mem_word(input logic [11:0] widx);
        return {widx, 5'd1, 3'b000, 5'd1, 7'h13};
    endfunction

    // ---------------- memory responder ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];

    int abs_cyc = 0;
    int cy      = 0;
    int p_ready = 100;
    int lat_min = 1;
    int lat_max = 1;

    logic        q_rst      = 1'b1;
    logic        q_stall    = 1'b0;
    logic        q_redirect = 1'b0;
    logic        q_inject   = 1'b0;
    logic [31:0] q_rpc      = 32'h0;

    // Advance one cycle and drive that cycle's inputs.
    task automatic step();
        @(posedge clk);
        #1;
        abs_cyc++;
        cy++;
        rst         = q_rst;
        stall       = q_stall;
        redirect    = q_redirect;
        redirect_pc = q_rpc;
        if (q_rst) memq.delete();
        imem_ready = ($urandom_range(99) < p_ready);
        if (q_inject) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (memq.size() > 0 && memq[0].due <= abs_cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(memq[0].addr[13:2]);
            void'(memq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
    endtask

    task automatic at(input int n);
        while (cy < n) step();
    endtask

    task automatic do_reset();
        q_rst = 1'b1; q_stall = 1'b0; q_redirect = 1'b0; q_inject = 1'b0;
        step();
        step();
        check("reset_req", {31'b0, imem_req}, 32'd0);
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        check("reset_instr", next_instruction, NOP);
        check("reset_pc", pc_out, RESET_PC);
        q_rst = 1'b0;
        step();
        cy = 0;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc = RESET_PC, m_lpc = 32'h0, m_instr = NOP, m_pcout = RESET_PC;
    logic        m_out = 1'b0, m_drop = 1'b0, m_valid = 1'b0, m_req;
    logic [63:0] mq[$];
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        logic        acc, resp, had;
        logic [63:0] e;
        if (rst) begin
            m_pc = RESET_PC; m_out = 1'b0; m_drop = 1'b0; mq.delete();
            m_instr = NOP; m_pcout = RESET_PC; m_valid = 1'b0; chk_en = 1'b1;
        end else begin
            acc  = !m_out && (mq.size() < DEPTH) && imem_ready;
            resp = imem_rvalid && m_out;
            if (redirect) begin
                mq.delete();
                m_instr = NOP; m_valid = 1'b0;
            end else begin
                had = (mq.size() > 0);
                if (!stall) begin
                    if (had) begin
                        e = mq.pop_front();
                        m_pcout = e[63:32]; m_instr = e[31:0]; m_valid = 1'b1;
                    end else begin
                        m_instr = NOP; m_valid = 1'b0;
                    end
                end
                if (resp && !m_drop) mq.push_back({m_lpc, imem_rdata});
            end
            if (redirect) m_drop = (m_out && !imem_rvalid) || acc;
            else if (resp) m_drop = 1'b0;
            if (acc) begin
                m_lpc = m_pc; m_out = 1'b1;
            end else if (resp) begin
                m_out = 1'b0;
            end
            if (redirect) m_pc = redirect_pc & ~32'h3;
            else if (acc) m_pc = m_pc + 32'd4;
        end
    end

    // Per-cycle comparison, then record any request the memory accepts.
    always @(negedge clk) begin
        if (chk_en) begin
            m_req = !rst && !m_out && (mq.size() < DEPTH);
            check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
            if (m_req) check("imem_addr", imem_addr, m_pc);
            check("next_instruction", next_instruction, m_instr);
            check("pc_out", pc_out, m_pcout);
            check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        end
        if (imem_req && imem_ready)
            memq.push_back('{addr: imem_addr, due: abs_cyc + int'($urandom_range(lat_max, lat_min))});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Straight-line fetch, 1-cycle memory.
        p_ready = 100; lat_min = 1; lat_max = 1;
        do_reset();
        check("t1_req_c0", {31'b0, imem_req}, 32'd1);
        check("t1_addr_c0", imem_addr, 32'h0);
        at(1); check("t1_req_c1", {31'b0, imem_req}, 32'd0);
        at(2); check("t1_addr_c2", imem_addr, 32'h4);
        at(3); check("t1_instr_c3", next_instruction, 32'h0000_8093);
               check("t1_pc_c3", pc_out, 32'h0);
               check("t1_valid_c3", {31'b0, valid_out}, 32'd1);
        at(4); check("t1_valid_c4", {31'b0, valid_out}, 32'd0);
               check("t1_addr_c4", imem_addr, 32'h8);
        at(5); check("t1_instr_c5", next_instruction, 32'h0010_8093);
               check("t1_pc_c5", pc_out, 32'h4);
        at(7); check("t1_instr_c7", next_instruction, 32'h0020_8093);
               check("t1_pc_c7", pc_out, 32'h8);

        // Stall for six cycles: buffer fills, issue stops, words drain back to back.
        do_reset();
        at(1); q_stall = 1'b1;
        at(5); check("t2_req_full", {31'b0, imem_req}, 32'd0);
               check("t2_valid_held", {31'b0, valid_out}, 32'd0);
               check("t2_instr_held", next_instruction, NOP);
        at(7); q_stall = 1'b0;
        at(9); check("t2_valid_c9", {31'b0, valid_out}, 32'd1);
               check("t2_pc_c9", pc_out, 32'h0);
               check("t2_instr_c9", next_instruction, 32'h0000_8093);
               check("t2_addr_c9", imem_addr, 32'h8);
        at(10); check("t2_valid_c10", {31'b0, valid_out}, 32'd1);
                check("t2_pc_c10", pc_out, 32'h4);
                check("t2_instr_c10", next_instruction, 32'h0010_8093);

        // Redirect to 0x103 while the request to 0x10 is outstanding.
        do_reset();
        at(7); lat_min = 3; lat_max = 3;
        at(8); check("t3_addr_c8", imem_addr, 32'h10);
        q_redirect = 1'b1; q_rpc = 32'h103;
        step();
        q_redirect = 1'b0; lat_min = 1; lat_max = 1;
        at(10); check("t3_valid_c10", {31'b0, valid_out}, 32'd0);
        at(11); check("t3_req_c11", {31'b0, imem_req}, 32'd0);
        at(12); check("t3_req_c12", {31'b0, imem_req}, 32'd1);
                check("t3_addr_c12", imem_addr, 32'h100);
        at(14); check("t3_valid_c14", {31'b0, valid_out}, 32'd0);
        at(15); check("t3_valid_c15", {31'b0, valid_out}, 32'd1);
                check("t3_pc_c15", pc_out, 32'h100);
                check("t3_instr_c15", next_instruction, 32'h0400_8093);

        // Redirect together with stall while the buffer holds two words.
        do_reset();
        at(1); q_stall = 1'b1;
        at(6); q_redirect = 1'b1; q_rpc = 32'h200;
        step();
        q_redirect = 1'b0; q_stall = 1'b0;
        at(8); check("t4_valid_c8", {31'b0, valid_out}, 32'd0);
               check("t4_instr_c8", next_instruction, NOP);
               check("t4_addr_c8", imem_addr, 32'h200);
        at(10); check("t4_valid_c10", {31'b0, valid_out}, 32'd0);
        at(11); check("t4_pc_c11", pc_out, 32'h200);
                check("t4_instr_c11", next_instruction, 32'h0800_8093);

        // Slow memory: ready low three cycles, four-cycle latency.
        p_ready = 0; lat_min = 4; lat_max = 4;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            at(c);
            check("t5_addr_wait", imem_addr, 32'h0);
            check("t5_req_wait", {31'b0, imem_req}, 32'd1);
        end
        p_ready = 100;
        at(3); check("t5_addr_c3", imem_addr, 32'h0);
        for (int w = 0; w < 5; w++) begin
            k = 0;
            while (!valid_out && k < 40) begin step(); k++; end
            check("t5_valid_seen", {31'b0, valid_out}, 32'd1);
            check("t5_pc_seq", pc_out, 32'(4 * w));
            check("t5_instr_seq", next_instruction, mem_word(12'(w)));
            step();
        end

        // Reset with a request in flight; late response right after reset.
        p_ready = 100; lat_min = 5; lat_max = 5;
        do_reset();
        at(1);
        q_rst = 1'b1;
        step();
        step();
        q_rst = 1'b0; q_inject = 1'b1; lat_min = 1; lat_max = 1;
        step();
        cy = 0;
        q_inject = 1'b0;
        check("t6_req_c0", {31'b0, imem_req}, 32'd1);
        check("t6_addr_c0", imem_addr, RESET_PC);
        k = 0;
        while (!valid_out && k < 40) begin step(); k++; end
        check("t6_valid_seen", {31'b0, valid_out}, 32'd1);
        check("t6_pc_first", pc_out, 32'h0);
        check("t6_instr_first", next_instruction, 32'h0000_8093);

        // Randomized traffic.
        p_ready = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 4000; i++) begin
            q_rst      = ($urandom_range(999) < 4);
            q_stall    = ($urandom_range(99) < 30);
            q_redirect = ($urandom_range(99) < 5);
            q_rpc      = $urandom;
            step();
        end
        q_rst = 1'b0; q_stall = 1'b0; q_redirect = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
